// File: rtl/sha512_dout16_pkg.sv
// Shared types for the sha512crypt 16-bit output serializer: FSM states,
// buffer entry layout and the halfword select helper.
package sha512_dout16_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_CSUM = 2'd2
   } state_t;

   typedef struct packed {
      logic        last;
      logic [63:0] data;
   } entry_t;

   function automatic logic [15:0] halfword(input logic [63:0] d, input logic [1:0] idx);
      logic [15:0] h;
      case (idx)
         2'd0:    h = d[15:0];
         2'd1:    h = d[31:16];
         2'd2:    h = d[47:32];
         default: h = d[63:48];
      endcase
      return h;
   endfunction

endpackage

// File: rtl/dout_fifo2.sv
// Two-entry synchronous FIFO of {last, data} entries; exposes both the head
// and the entry behind it so the serializer can look ahead across a pop.
module dout_fifo2
   import sha512_dout16_pkg::*;
(
   input  logic       CLK,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  entry_t     din,
   output entry_t     head,
   output entry_t     second,
   output logic       full,
   output logic       empty,
   output logic [1:0] count
);

   entry_t     mem [2];
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic       push_ok;
   logic       pop_ok;

   assign push_ok = push && (count_reg != 2'd2);
   assign pop_ok  = pop && (count_reg != 2'd0);

   always_ff @(posedge CLK) begin
      if (rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= ~wr_ptr_reg;
         if (pop_ok)
            rd_ptr_reg <= ~rd_ptr_reg;
         if (push_ok && !pop_ok)
            count_reg <= count_reg + 2'd1;
         else if (pop_ok && !push_ok)
            count_reg <= count_reg - 2'd1;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge CLK) begin
      if (push_ok)
         mem[wr_ptr_reg] <= din;
   end

   assign head   = mem[rd_ptr_reg];
   assign second = mem[~rd_ptr_reg];
   assign full   = (count_reg == 2'd2);
   assign empty  = (count_reg == 2'd0);
   assign count  = count_reg;

endmodule

// File: rtl/sha512_dout16.sv
// 64-bit to 16-bit result serializer for the sha512crypt core.
// Optional per-result XOR checksum halfword: define SHA512_DOUT_CSUM_EN.
module sha512_dout16
   import sha512_dout16_pkg::*;
#(
   parameter int N_WORDS = 8
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic [63:0] in_data,
   input  logic        in_last,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] out_data,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err_len
);

   localparam int WCW = $clog2(N_WORDS + 1);

   state_t      state_reg, state_next;
   logic [1:0]  hidx_reg, hidx_next;
   logic [15:0] out_data_reg, out_data_next;
   logic        out_last_reg, out_last_next;
   logic        out_valid_reg, out_valid_next;
   logic [15:0] csum_next;
   logic [WCW-1:0] wcnt_reg;
   logic        err_reg;

   entry_t      in_entry, head, second, head_after;
   logic        full, empty;
   logic [1:0]  count, count_next;
   logic        push, pop, fire;

   assign in_entry = {in_last, in_data};
   assign in_ready = !rst && !full;
   assign push     = in_valid && in_ready;
   assign fire     = out_valid_reg && out_ready;
   assign pop      = (state_reg == S_SEND) && fire && (hidx_reg == 2'd3);

   dout_fifo2 u_fifo (
      .CLK    (CLK),
      .rst    (rst),
      .push   (push),
      .pop    (pop),
      .din    (in_entry),
      .head   (head),
      .second (second),
      .full   (full),
      .empty  (empty),
      .count  (count)
   );

`ifdef SHA512_DOUT_CSUM_EN
   localparam bit CSUM_EN = 1'b1;
   logic [15:0] csum_reg;

   always_ff @(posedge CLK) begin
      if (rst)
         csum_reg <= '0;
      else
         csum_reg <= csum_next;
   end

   always_comb begin
      csum_next = csum_reg;
      if (fire && state_reg == S_SEND)
         csum_next = csum_reg ^ out_data_reg;
      else if (fire && state_reg == S_CSUM)
         csum_next = '0;
   end
`else
   localparam bit CSUM_EN = 1'b0;
   assign csum_next = '0;
`endif

   // Look ahead to the entry that will be at the head after this edge, so the
   // output register is loaded in the same cycle the word lands in the buffer.
   always_comb begin
      head_after = head;
      count_next = count;
      if (pop)
         head_after = (count == 2'd2) ? second : in_entry;
      else if (empty)
         head_after = in_entry;
      if (push && !pop)
         count_next = count + 2'd1;
      else if (pop && !push)
         count_next = count - 2'd1;
   end

   always_comb begin
      state_next = state_reg;
      hidx_next  = hidx_reg;
      case (state_reg)
         S_IDLE: if (count_next != 2'd0) state_next = S_SEND;
         S_SEND: begin
            if (fire) begin
               hidx_next = hidx_reg + 2'd1;
               if (hidx_reg == 2'd3) begin
                  if (CSUM_EN && head.last)
                     state_next = S_CSUM;
                  else if (count_next == 2'd0)
                     state_next = S_IDLE;
               end
            end
         end
         S_CSUM: if (fire) state_next = (count_next != 2'd0) ? S_SEND : S_IDLE;
         default: state_next = S_IDLE;
      endcase

      out_valid_next = (state_next != S_IDLE);
      out_data_next  = out_data_reg;
      out_last_next  = 1'b0;
      if (state_next == S_SEND) begin
         out_data_next = halfword(head_after.data, hidx_next);
         out_last_next = !CSUM_EN && head_after.last && (hidx_next == 2'd3);
      end else if (state_next == S_CSUM) begin
         out_data_next = csum_next;
         out_last_next = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         hidx_reg      <= 2'd0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hidx_reg      <= hidx_next;
         out_data_reg  <= out_data_next;
         out_last_reg  <= out_last_next;
         out_valid_reg <= out_valid_next;
      end
   end

   // Result length check: counter returns to 0 on every last word and on
   // reaching N_WORDS without one.
   always_ff @(posedge CLK) begin
      if (rst) begin
         wcnt_reg <= '0;
         err_reg  <= 1'b0;
      end else if (push) begin
         if (in_last) begin
            wcnt_reg <= '0;
            if (int'(wcnt_reg) + 1 != N_WORDS)
               err_reg <= 1'b1;
         end else if (int'(wcnt_reg) + 1 == N_WORDS) begin
            wcnt_reg <= '0;
            err_reg  <= 1'b1;
         end else begin
            wcnt_reg <= wcnt_reg + WCW'(1);
         end
      end
   end

   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;
   assign out_valid = out_valid_reg;
   assign err_len   = err_reg;

endmodule

// File: tb/tb_sha512_dout16.sv
// Self-checking bench for sha512_dout16: random traffic against a queue model
// of the halfword stream, checksum and result-length error.
module tb_sha512_dout16;

   localparam int NW = 8;
`ifdef SHA512_DOUT_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        err_len;

   int checks = 0;
   int failures = 0;
   int hold_viol = 0;
   bit timed_out = 0;

   logic [64:0] src_q[$];
   logic [16:0] exp_q[$];
   logic [16:0] got_q[$];

   sha512_dout16 #(.N_WORDS(NW)) dut (
      .CLK       (CLK),
      .rst       (rst),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_len   (err_len)
   );

   always #5 CLK = ~CLK;

   // Expected halfword stream: four halfwords per word, LS first; last flag on
   // the final data halfword, or on an appended XOR checksum when enabled.
   function automatic void build_expected();
      logic [15:0] acc = '0;
      logic [15:0] hw;
      logic [64:0] w;
      exp_q.delete();
      foreach (src_q[i]) begin
         w = src_q[i];
         for (int h = 0; h < 4; h++) begin
            hw = w[16*h +: 16];
            acc = acc ^ hw;
            exp_q.push_back({(!CSUM && w[64] && h == 3), hw});
         end
         if (CSUM && w[64]) begin
            exp_q.push_back({1'b1, acc});
            acc = '0;
         end
      end
   endfunction

   function automatic logic model_err();
      int n = 0;
      logic e = 1'b0;
      foreach (src_q[i]) begin
         n++;
         if (src_q[i][64]) begin
            if (n != NW) e = 1'b1;
            n = 0;
         end else if (n == NW) begin
            e = 1'b1;
            n = 0;
         end
      end
      return e;
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge CLK);
      rst = 1'b0;
   endtask

   // Drives src_q[first_idx..] and collects output handshakes into got_q.
   task automatic run_stream(input int first_idx, input int in_pct, input int out_pct);
      int idx = first_idx;
      int cyc = 0;
      bit stalled = 0;
      logic [16:0] held = '0;
      timed_out = 0;
      while (idx < src_q.size() || got_q.size() < exp_q.size()) begin
         if (idx < src_q.size() && int'($urandom_range(99)) < in_pct) begin
            in_valid = 1'b1;
            {in_last, in_data} = src_q[idx];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = (int'($urandom_range(99)) < out_pct);
         #1;
         if (stalled && (!out_valid || {out_last, out_data} !== held)) hold_viol++;
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) got_q.push_back({out_last, out_data});
         stalled = out_valid && !out_ready;
         held = {out_last, out_data};
         @(negedge CLK);
         cyc++;
         if (cyc > 3000) begin
            timed_out = 1;
            break;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (6) begin
         #1;
         if (out_valid) got_q.push_back({out_last, out_data});
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0000", out_data); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", out_last); end
      checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_len); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      rst = 1'b0;
      @(negedge CLK); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
      $display("test_reset done");
      @(negedge CLK);
   endtask

   task automatic test_single();
      do_reset();
      src_q.delete(); got_q.delete();
      src_q.push_back(65'h1_0123456789ABCDEF);
      if (CSUM) src_q.push_back(65'h1_0000000000000001);
      build_expected();
      in_valid = 1'b1; {in_last, in_data} = src_q[0]; out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      checks++; if ({out_valid, out_data} !== {1'b1, 16'hCDEF}) begin failures++; $display("FAIL single_latency got=%b/%h exp=1/cdef", out_valid, out_data); end
      run_stream(1, 100, 100);
      checks++; if (timed_out) begin failures++; $display("FAIL single_timeout got=1 exp=0"); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_hw[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      $display("test_single: %0d halfwords", got_q.size());
   endtask

   task automatic test_backpressure();
      do_reset();
      src_q.delete(); got_q.delete();
      src_q.push_back(65'h1_0123456789ABCDEF);
      build_expected();
      in_valid = 1'b1; {in_last, in_data} = src_q[0]; out_ready = 1'b0;
      @(negedge CLK);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if ({out_valid, out_data} !== {1'b1, 16'hCDEF}) begin failures++; $display("FAIL bp_hw0 got=%b/%h exp=1/cdef", out_valid, out_data); end
      if (out_valid) got_q.push_back({out_last, out_data});
      @(negedge CLK);
      for (int k = 0; k < 5; k++) begin
         out_ready = 1'b0;
         #1;
         checks++; if ({out_valid, out_data} !== {1'b1, 16'h89AB}) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/89ab", k, out_valid, out_data); end
         @(negedge CLK);
      end
      run_stream(1, 0, 100);
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_hw[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      $display("test_backpressure: %0d halfwords", got_q.size());
   endtask

   task automatic test_full();
      bit acc = 0;
      int fires = 0;
      int fires_at_accept = -1;
      do_reset();
      src_q.delete(); got_q.delete();
      for (int i = 0; i < 3; i++) src_q.push_back({(i == 2), $urandom, $urandom});
      build_expected();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; {in_last, in_data} = src_q[i];
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_accept[%0d] got=%b exp=1", i, in_ready); end
         @(negedge CLK);
      end
      in_valid = 1'b1; {in_last, in_data} = src_q[2];
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low got=%b exp=0", in_ready); end
      for (int c = 0; c < 20 && !acc; c++) begin
         out_ready = 1'b1;
         #1;
         if (in_valid && in_ready) begin acc = 1; fires_at_accept = fires; end
         if (out_valid && out_ready) begin got_q.push_back({out_last, out_data}); fires++; end
         @(negedge CLK);
      end
      in_valid = 1'b0;
      checks++; if (fires_at_accept != 4) begin failures++; $display("FAIL full_third_accept got=%0d exp=4 halfwords before accept", fires_at_accept); end
      run_stream(3, 0, 100);
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL full_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_hw[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      $display("test_full: %0d halfwords", got_q.size());
   endtask

   task automatic test_len_err();
      bit acc;
      do_reset();
      src_q.delete(); got_q.delete();
      for (int i = 0; i < 8; i++) src_q.push_back({(i == 7), $urandom, $urandom});
      build_expected();
      run_stream(0, 100, 100);
      checks++; if (err_len !== model_err()) begin failures++; $display("FAIL len_ok_err got=%b exp=%b", err_len, model_err()); end
      for (int i = 0; i < 7; i++) src_q.push_back({(i == 6), $urandom, $urandom});
      build_expected();
      for (int w = 8; w < 15; w++) begin
         acc = 0;
         in_valid = 1'b1; {in_last, in_data} = src_q[w];
         for (int c = 0; c < 40 && !acc; c++) begin
            out_ready = 1'b1;
            #1;
            if (in_ready) acc = 1;
            if (w == 14 && acc) begin
               checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL len_err_early got=%b exp=0", err_len); end
            end
            if (out_valid) got_q.push_back({out_last, out_data});
            @(negedge CLK);
         end
         if (!acc) begin checks++; failures++; $display("FAIL len_write_timeout word=%0d got=stalled exp=accepted", w); end
      end
      in_valid = 1'b0;
      #1;
      checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL len_err_set got=%b exp=1", err_len); end
      if (out_valid) got_q.push_back({out_last, out_data});
      @(negedge CLK);
      run_stream(15, 100, 100);
      checks++; if (err_len !== model_err()) begin failures++; $display("FAIL len_err_sticky got=%b exp=%b", err_len, model_err()); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL len_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL len_hw[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      do_reset();
      #1;
      checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL len_err_cleared got=%b exp=0", err_len); end
      @(negedge CLK);
      $display("test_len_err: %0d halfwords", got_q.size());
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1'b1; in_last = 1'b1; in_data = {$urandom, $urandom}; out_ready = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0;
      repeat (2) @(negedge CLK);
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); end
      @(negedge CLK); #1;
      checks++; if ({out_valid, in_ready} !== 2'b00) begin failures++; $display("FAIL mid_rst_outputs got=%b%b exp=00", out_valid, in_ready); end
      rst = 1'b0;
      @(negedge CLK);
      src_q.delete(); got_q.delete();
      src_q.push_back(65'h1_AAAA5555FFFF0000);
      build_expected();
      run_stream(0, 100, 100);
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL mid_hw[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      $display("test_reset_mid: %0d halfwords", got_q.size());
   endtask

   task automatic test_random();
      int len;
      do_reset();
      src_q.delete(); got_q.delete();
      hold_viol = 0;
      for (int r = 0; r < 4; r++) begin
         len = int'($urandom_range(6, 9));
         for (int i = 0; i < len; i++) src_q.push_back({(i == len - 1), $urandom, $urandom});
      end
      build_expected();
      run_stream(0, 60, 60);
      checks++; if (timed_out) begin failures++; $display("FAIL rand_timeout got=1 exp=0"); end
      checks++; if (hold_viol != 0) begin failures++; $display("FAIL rand_hold got=%0d exp=0 unstable stalls", hold_viol); end
      checks++; if (err_len !== model_err()) begin failures++; $display("FAIL rand_err got=%b exp=%b", err_len, model_err()); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_hw[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      $display("test_random: %0d words, %0d halfwords", src_q.size(), got_q.size());
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_full();
      test_len_err();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
